// File: rtl/reservoir_sequencer_pkg.sv
// Shared types and helpers for the reservoir input sequencer and its mask multiplier.
package reservoir_sequencer_pkg;

    localparam int MASK_W   = 16;
    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_RES,
        S_EMIT,
        S_DONE
    } seq_state_e;

    // Clamp a 32-bit unsigned value to the 16-bit reservoir input range.
    function automatic logic [SAMPLE_W-1:0] sat_u16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/reservoir_mask_mult.sv
// Per-node input mask register file plus the multiply / shift / saturate
// that produces the masked reservoir drive for (node_idx, sample).
module reservoir_mask_mult
    import reservoir_sequencer_pkg::*;
#(
    parameter int NUM_VIRTUAL_NODES = 10,
    parameter int MASK_FRAC         = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [$clog2(NUM_VIRTUAL_NODES)-1:0] wr_addr,
    input  logic [MASK_W-1:0]                    wr_data,
    input  logic [$clog2(NUM_VIRTUAL_NODES)-1:0] node_idx,
    input  logic [SAMPLE_W-1:0]                  sample,
    output logic [SAMPLE_W-1:0]                  masked
);

    localparam int NW = $clog2(NUM_VIRTUAL_NODES);

    logic [MASK_W-1:0] mask_q [NUM_VIRTUAL_NODES];
    logic [MASK_W-1:0] mask_sel;
    logic [31:0]       product;

    // Addresses at or beyond NUM_VIRTUAL_NODES match no entry and are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_VIRTUAL_NODES; i++) mask_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_VIRTUAL_NODES; i++)
                if (wr_addr == NW'(i)) mask_q[i] <= wr_data;
        end
    end

    always_comb begin
        mask_sel = '0;
        for (int i = 0; i < NUM_VIRTUAL_NODES; i++)
            if (node_idx == NW'(i)) mask_sel = mask_q[i];
    end

    assign product = {16'b0, sample} * {16'b0, mask_sel};
    assign masked  = sat_u16(product >> MASK_FRAC);

endmodule

// File: rtl/reservoir_sequencer.sv
// Time-multiplexes input samples into the delay-feedback reservoir, one masked
// step per virtual node, and streams each resulting state to the readout.
// Optional watchdog on the reservoir step: define RES_WATCHDOG_EN.
module reservoir_sequencer
    import reservoir_sequencer_pkg::*;
#(
    parameter int NUM_VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH        = 32,
    parameter int MASK_FRAC         = 8,
    parameter int WDOG_CYCLES       = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [31:0]                          num_samples,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    input  logic                                 mask_wr_en,
    input  logic [$clog2(NUM_VIRTUAL_NODES)-1:0] mask_wr_addr,
    input  logic [MASK_W-1:0]                    mask_wr_data,
    input  logic                                 sample_valid,
    output logic                                 sample_ready,
    input  logic [SAMPLE_W-1:0]                  sample_data,
    output logic                                 res_en,
    output logic [DATA_WIDTH-1:0]                res_din,
    input  logic                                 res_valid,
    input  logic [DATA_WIDTH-1:0]                res_dout,
    output logic                                 state_valid,
    input  logic                                 state_ready,
    output logic [DATA_WIDTH-1:0]                state_data,
    output logic [$clog2(NUM_VIRTUAL_NODES)-1:0] state_node_idx,
    output logic                                 state_last
);

    localparam int NW = $clog2(NUM_VIRTUAL_NODES);

    if (NUM_VIRTUAL_NODES < 2 || DATA_WIDTH < SAMPLE_W || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("reservoir_sequencer: unsupported parameter set");
    end

    seq_state_e            st;
    logic [31:0]           num_q;
    logic [31:0]           sample_cnt;
    logic [NW-1:0]         node_idx;
    logic [SAMPLE_W-1:0]   sample_q;
    logic                  wait_first;
    logic                  last_node;
    logic                  last_sample;
    logic [NW-1:0]         mm_node;
    logic [SAMPLE_W-1:0]   mm_sample;
    logic [SAMPLE_W-1:0]   masked;

`ifdef RES_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wdog_cnt;
    logic           err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign last_node   = (node_idx == NW'(NUM_VIRTUAL_NODES - 1));
    assign last_sample = (sample_cnt + 32'd1 == num_q);

    // res_din is registered on entry to ISSUE, so the multiplier looks one
    // step ahead: the incoming sample in FETCH, the next node in EMIT.
    assign mm_sample = (st == S_FETCH) ? sample_data : sample_q;
    assign mm_node   = (st == S_EMIT) ? node_idx + NW'(1) : node_idx;

    reservoir_mask_mult #(
        .NUM_VIRTUAL_NODES (NUM_VIRTUAL_NODES),
        .MASK_FRAC         (MASK_FRAC)
    ) u_mask_mult (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (mask_wr_en && !busy),
        .wr_addr  (mask_wr_addr),
        .wr_data  (mask_wr_data),
        .node_idx (mm_node),
        .sample   (mm_sample),
        .masked   (masked)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st             <= S_IDLE;
            num_q          <= '0;
            sample_cnt     <= '0;
            node_idx       <= '0;
            sample_q       <= '0;
            wait_first     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sample_ready   <= 1'b0;
            res_en         <= 1'b0;
            res_din        <= '0;
            state_valid    <= 1'b0;
            state_data     <= '0;
            state_node_idx <= '0;
            state_last     <= 1'b0;
`ifdef RES_WATCHDOG_EN
            wdog_cnt       <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            res_en <= 1'b0;
            case (st)
                S_IDLE: if (start) begin
                    num_q      <= num_samples;
                    sample_cnt <= '0;
                    node_idx   <= '0;
`ifdef RES_WATCHDOG_EN
                    err_q      <= 1'b0;
`endif
                    if (num_samples == 32'd0) begin
                        st <= S_DONE;
                    end else begin
                        st           <= S_FETCH;
                        busy         <= 1'b1;
                        sample_ready <= 1'b1;
                    end
                end
                S_FETCH: if (sample_valid && sample_ready) begin
                    sample_q     <= sample_data;
                    sample_ready <= 1'b0;
                    res_en       <= 1'b1;
                    res_din      <= DATA_WIDTH'(masked);
                    st           <= S_ISSUE;
                end
                S_ISSUE: begin
                    wait_first <= 1'b1;
`ifdef RES_WATCHDOG_EN
                    wdog_cnt   <= '0;
`endif
                    st         <= S_WAIT_RES;
                end
                S_WAIT_RES: begin
                    // First cycle ignored: the reservoir drops valid only as en lands.
                    wait_first <= 1'b0;
                    if (!wait_first && res_valid) begin
                        state_data     <= res_dout;
                        state_node_idx <= node_idx;
                        state_last     <= last_node && last_sample;
                        state_valid    <= 1'b1;
                        st             <= S_EMIT;
                    end
`ifdef RES_WATCHDOG_EN
                    else if (wdog_cnt == WDW'(WDOG_CYCLES - 1)) begin
                        err_q <= 1'b1;
                        busy  <= 1'b0;
                        st    <= S_DONE;
                    end else begin
                        wdog_cnt <= wdog_cnt + WDW'(1);
                    end
`endif
                end
                S_EMIT: if (state_ready) begin
                    state_valid <= 1'b0;
                    state_last  <= 1'b0;
                    if (!last_node) begin
                        node_idx <= node_idx + NW'(1);
                        res_en   <= 1'b1;
                        res_din  <= DATA_WIDTH'(masked);
                        st       <= S_ISSUE;
                    end else begin
                        node_idx   <= '0;
                        sample_cnt <= sample_cnt + 32'd1;
                        if (last_sample) begin
                            busy <= 1'b0;
                            st   <= S_DONE;
                        end else begin
                            sample_ready <= 1'b1;
                            st           <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    st   <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reservoir_sequencer.sv
// Randomized bench: a behavioural reservoir, sample source and readout drive the
// sequencer; expected masked inputs and state ordering come from a scoreboard.
module tb_reservoir_sequencer;

    localparam int N    = 10;
    localparam int DW   = 32;
    localparam int NW   = 4;
    localparam int WDOG = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   num_samples = '0;
    logic          busy, done, err;
    logic          mask_wr_en = 1'b0;
    logic [NW-1:0] mask_wr_addr = '0;
    logic [15:0]   mask_wr_data = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [15:0]   sample_data = '0;
    logic          res_en;
    logic [DW-1:0] res_din;
    logic          res_valid;
    logic [DW-1:0] res_dout = '0;
    logic          state_valid;
    logic          state_ready = 1'b0;
    logic [DW-1:0] state_data;
    logic [NW-1:0] state_node_idx;
    logic          state_last;

    always #5 clk = ~clk;

    reservoir_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .busy(busy), .done(done), .err(err),
        .mask_wr_en(mask_wr_en), .mask_wr_addr(mask_wr_addr), .mask_wr_data(mask_wr_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
        .res_en(res_en), .res_din(res_din), .res_valid(res_valid), .res_dout(res_dout),
        .state_valid(state_valid), .state_ready(state_ready), .state_data(state_data),
        .state_node_idx(state_node_idx), .state_last(state_last)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference state
    int unsigned   mask_m [N];
    logic [15:0]   smp_q [$];
    logic [DW-1:0] exp_din [$];
    logic [DW-1:0] dq [$];
    int            smp_idx, st_cnt, total, res_en_cnt, done_cnt, done_base, en_base;
    bit            run_active, stall, hold;
    int            res_cnt;
    logic [DW-1:0] res_pend;

    assign res_valid = !hold && (res_cnt == 0) && !res_en;

    function automatic logic [DW-1:0] ref_din(input int unsigned s, input int unsigned m);
        longint unsigned p;
        p = (longint'(s) * longint'(m)) / 256;
        if (p > 65535) p = 65535;
        return DW'(p);
    endfunction

    // Environment: reservoir with 5-cycle steps, random sample source and readout.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            sample_valid = 1'b0;
            state_ready  = 1'b0;
            continue;
        end
        if (res_en) begin
            res_en_cnt++;
            chk("res_en_pending", exp_din.size() > 0, 1);
            if (exp_din.size() > 0) chk("res_din", res_din, exp_din.pop_front());
            chk("res_en_while_state_valid", state_valid, 0);
            res_pend = $urandom;
            res_dout = $urandom;
            res_cnt  = 5;
        end else if (res_cnt > 0) begin
            res_cnt--;
            if (res_cnt == 0) begin
                res_dout = res_pend;
                dq.push_back(res_pend);
            end
        end
        if (run_active && smp_idx < smp_q.size()) begin
            sample_valid = ($urandom_range(0, 3) != 0);
            sample_data  = sample_valid ? smp_q[smp_idx] : 16'($urandom);
        end else begin
            sample_valid = 1'b0;
            sample_data  = '0;
        end
        if (sample_valid && sample_ready) smp_idx++;
        state_ready = !stall && ($urandom_range(0, 2) != 0);
        if (state_valid && state_ready) begin
            chk("state_pending", dq.size() > 0, 1);
            if (dq.size() > 0) chk("state_data", state_data, dq.pop_front());
            chk("state_node", state_node_idx, st_cnt % N);
            chk("state_last", state_last, st_cnt == total - 1);
            st_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic write_mask(input int addr, input logic [15:0] data, input bit model);
        mask_wr_en   = 1'b1;
        mask_wr_addr = NW'(addr);
        mask_wr_data = data;
        @(negedge clk);
        mask_wr_en = 1'b0;
        if (model && addr < N) mask_m[addr] = data;
    endtask

    task automatic run_start(input logic [15:0] s [$]);
        smp_q = s;
        exp_din.delete();
        dq.delete();
        foreach (s[i]) for (int n = 0; n < N; n++) exp_din.push_back(ref_din(s[i], mask_m[n]));
        total      = s.size() * N;
        st_cnt     = 0;
        smp_idx    = 0;
        done_base  = done_cnt;
        en_base    = res_en_cnt;
        run_active = 1'b1;
        num_samples = s.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic run_wait();
        int t = 0;
        int lim = 400 * smp_q.size() + 200;
        while (!done && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("run_in_time", t < lim, 1);
        chk("busy_at_done", busy, 0);
        run_active = 1'b0;
        repeat (3) @(negedge clk);
        chk("samples_used", smp_idx, smp_q.size());
        chk("states_seen", st_cnt, total);
        chk("din_left", exp_din.size(), 0);
        chk("res_en_count", res_en_cnt - en_base, total);
        chk("done_once", done_cnt - done_base, 1);
    endtask

    task automatic rand_masks();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0: write_mask(i, 16'h0000, 1);
                1: write_mask(i, 16'h0100, 1);
                default: write_mask(i, 16'($urandom), 1);
            endcase
        end
    endtask

    initial begin
        logic [15:0] s [$];
        logic [DW-1:0] held;
        bit changed;
        int t, e0, d0;

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, done, err, sample_ready, res_en, state_valid, state_last, state_node_idx}, 0);
        chk("rst_data", {res_din, state_data}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Unity masks, two samples
        for (int i = 0; i < N; i++) write_mask(i, 16'h0100, 1);
        s = '{16'h0010, 16'h0020};
        run_start(s);
        run_wait();

        // Saturation on node 3, zero mask on node 4
        write_mask(3, 16'h0200, 1);
        write_mask(4, 16'h0000, 1);
        s = '{16'hFFFF};
        run_start(s);
        run_wait();

        // Readout stalled for 50 cycles while a state is pending
        stall = 1'b1;
        s = '{16'($urandom)};
        run_start(s);
        t = 0;
        while (!state_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("stall_state_seen", t < 200, 1);
        held = state_data;
        e0 = res_en_cnt;
        changed = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (state_data !== held || !state_valid) changed = 1'b1;
        end
        chk("stall_stable", changed, 0);
        chk("stall_no_res_en", res_en_cnt - e0, 0);
        stall = 1'b0;
        run_wait();

        // Zero-sample run
        e0 = res_en_cnt;
        d0 = done_cnt;
        num_samples = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done_early", done, 0);
        chk("zero_busy", busy, 0);
        chk("zero_ready_a", sample_ready, 0);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_ready_b", sample_ready, 0);
        repeat (2) @(negedge clk);
        chk("zero_res_en", res_en_cnt - e0, 0);
        chk("zero_done_once", done_cnt - d0, 1);

        // Mask writes while busy are dropped; out-of-range address ignored
        write_mask(12, 16'hABCD, 0);
        s = '{16'($urandom), 16'($urandom)};
        run_start(s);
        write_mask(2, 16'h0400, 0);
        write_mask(7, 16'h0001, 0);
        run_wait();

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            rand_masks();
            s.delete();
            for (int k = 0; k < $urandom_range(1, 4); k++) s.push_back(16'($urandom));
            run_start(s);
            run_wait();
        end

        // Asynchronous reset while waiting on the reservoir
        s = '{16'($urandom), 16'($urandom)};
        run_start(s);
        t = 0;
        while (!res_en && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("midrst_res_en_seen", t < 200, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ctrl", {busy, done, err, sample_ready, res_en, state_valid, state_last, state_node_idx}, 0);
        chk("midrst_data", {res_din, state_data}, 0);
        run_active = 1'b0;
        exp_din.delete();
        dq.delete();
        res_cnt = 0;
        for (int i = 0; i < N; i++) mask_m[i] = 0;
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        rst = 1'b1;
        @(negedge clk);
        s = '{16'($urandom)};
        run_start(s);
        run_wait();
        rand_masks();
        s = '{16'($urandom), 16'($urandom)};
        run_start(s);
        run_wait();

`ifdef RES_WATCHDOG_EN
        hold = 1'b1;
        s = '{16'h1234};
        run_start(s);
        t = 0;
        while (!res_en && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("wdog_res_en_seen", t < 200, 1);
        repeat (WDOG) @(negedge clk);
        chk("wdog_err_early", err, 0);
        @(negedge clk);
        chk("wdog_err", err, 1);
        t = 0;
        while (!done && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("wdog_done", done, 1);
        hold = 1'b0;
        run_active = 1'b0;
        repeat (8) @(negedge clk);
        exp_din.delete();
        dq.delete();
        num_samples = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("wdog_err_cleared", err, 0);
        repeat (3) @(negedge clk);
`else
        chk("err_tied_low", err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0t exp=<2000000", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reservoir_sequencer.md
Name: reservoir_sequencer

Overview:
Controller that time-multiplexes input samples into the delay-feedback reservoir. For each input sample it issues one masked reservoir step per virtual node. It waits for the reservoir to report the step complete, then streams each resulting reservoir state to the readout. It sits between the sample source / host config registers and the reservoir, and owns the reservoir's en/din pins.

Parameters:
NUM_VIRTUAL_NODES, 10, virtual nodes per sample; must match the reservoir instance.
DATA_WIDTH, 32, reservoir din/dout width.
MASK_FRAC, 8, fractional bits of the unsigned mask values (Q8.8 by default).
WDOG_CYCLES, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  1-cycle pulse; begins a run when idle.
num_samples  in  32  samples per run; sampled at start.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  1-cycle pulse at the end of a run.
err  out  1  sticky watchdog error; cleared by start.
mask_wr_en  in  1  mask write strobe.
mask_wr_addr  in  $clog2(NUM_VIRTUAL_NODES)  mask index.
mask_wr_data  in  16  mask value, unsigned Q(16-MASK_FRAC).MASK_FRAC.
sample_valid  in  1  input sample available.
sample_ready  out  1  sequencer accepts the sample.
sample_data  in  16  unsigned input sample.
res_en  out  1  1-cycle reservoir step request.
res_din  out  DATA_WIDTH  masked input to the reservoir.
res_valid  in  1  reservoir idle / step complete.
res_dout  in  DATA_WIDTH  reservoir state tap.
state_valid  out  1  reservoir state available to the readout.
state_ready  in  1  readout accepts the state.
state_data  out  DATA_WIDTH  captured res_dout.
state_node_idx  out  $clog2(NUM_VIRTUAL_NODES)  node index of state_data.
state_last  out  1  high with the last node of the last sample.

Behaviour:
Reset (rst=0, async):
- state IDLE; every output 0; all counters 0; masks 0; err 0.

States: IDLE, FETCH, ISSUE, WAIT_RES, EMIT, DONE.
- IDLE: start=1 latches num_samples, clears sample/node counters and err.
  - num_samples==0: go to DONE.
  - otherwise: go to FETCH.
  - start is ignored in every other state.
- FETCH: sample_ready=1. When sample_valid & sample_ready, register sample_data and go to ISSUE. No combinational path from sample_valid to sample_ready.
- ISSUE: res_en=1 for exactly one cycle. res_din = min((sample_reg × mask[node_idx]) >> MASK_FRAC, 16'hFFFF), zero-extended to DATA_WIDTH. The product is a full 32-bit unsigned value; saturate, never wrap. Next state WAIT_RES.
- WAIT_RES: res_valid is ignored in the first WAIT_RES cycle (the reservoir deasserts valid combinationally with en). The first later cycle with res_valid=1 registers res_dout and node_idx and goes to EMIT. No fixed reservoir latency is assumed; the current reservoir completes in 5 cycles after res_en.
- EMIT: state_valid=1; state_data, state_node_idx and state_last stay stable until state_ready. On the handshake:
  - node_idx < NUM_VIRTUAL_NODES-1: node_idx++ and go to ISSUE (same sample).
  - else: node_idx=0, sample_cnt++. Go to DONE if sample_cnt+1 == num_samples, otherwise go to FETCH.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- busy is registered: 1 in FETCH/ISSUE/WAIT_RES/EMIT.
- Mask writes: accepted only when not busy. mask_wr_en while busy is dropped. An address ≥ NUM_VIRTUAL_NODES is ignored.
- Throughput: at most one res_en per node step. A stalled state_ready back-pressures the reservoir; no state is lost or duplicated.
- Reset mid-run: the run is aborted immediately, no done pulse, masks cleared.

Optional Feature:
Macro RES_WATCHDOG_EN.
- Defined: a counter runs in WAIT_RES. If res_valid has not been seen after WDOG_CYCLES cycles, set err=1 and go to DONE (done still pulses). The counter clears on every entry to WAIT_RES.
- Undefined: no counter; err is tied 0; WAIT_RES waits indefinitely.

Decomposition:
- Shared package: state enum, MASK_W=16, SAMPLE_W=16, and the saturation helper function.
- One natural sub-module: reservoir_mask_mult. It holds the mask register file plus the multiply/shift/saturate, returning the masked value for (node_idx, sample).

Test Plan:
- Masks all 16'h0100, num_samples=2, samples 0x0010, 0x0020 → 20 res_en pulses, res_din 0x10 ×10 then 0x20 ×10, 20 states with node_idx 0..9 twice, state_last only on the 20th, one done.
- mask[3]=16'h0200, sample 0xFFFF → node 3 res_din saturates to 0x0000FFFF; mask[4]=0 gives 0.
- state_ready held low 50 cycles during EMIT → state_data stable, no res_en issued, and no extra states after release.
- num_samples=0 start → done 2 cycles later, no res_en, sample_ready never 1.
- rst asserted in WAIT_RES mid-run → all outputs 0 asynchronously, no done; a fresh start afterwards runs cleanly (masks must be rewritten).
- RES_WATCHDOG_EN, res_valid forced 0 → err=1 and done at WDOG_CYCLES+1 cycles after res_en; a new start clears err.
